// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between a multiply requester and seq_multiplier.
interface seq_multiplier_if
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   dataOut;

  modport master (
    output start, signed_mode, dataA, dataB,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, signed_mode, dataA, dataB,
    output busy, done, dataOut
  );

endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-and-add multiplier: one iteration per RUN cycle, fixed WIDTH+2 cycle
// turnaround; signed operands are handled as magnitudes with the sign applied at FIN.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  seq_multiplier_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_dataOut;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic                 w_last;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
  // correct magnitude when read as unsigned.
  assign w_absA = (bus.signed_mode && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
  assign w_absB = (bus.signed_mode && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
  assign w_last = (r_count == CW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataOut <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_absA};
            r_mplier <= w_absB;
            r_neg    <= bus.signed_mode & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mplier <= r_mplier >> 1;
          r_mcand  <= r_mcand << 1;
          r_count  <= r_count + CW'(1);
        end
        FIN: begin
          r_dataOut <= r_neg ? -r_acc : r_acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dataOut = r_dataOut;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits, legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 signed_mode  input  1  0 = unsigned, 1 = two's-complement; sampled with start.
REQ-006 dataA  input  WIDTH  multiplicand; sampled with start.
REQ-007 dataB  input  WIDTH  multiplier; sampled with start.
REQ-008 busy  output  1  high while state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking a new dataOut value.
REQ-010 dataOut  output  2*WIDTH  registered product of the most recent completed operation.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-012 Transitions SHALL be:
- IDLE to RUN on start=1.
- RUN to FIN after WIDTH iterations.
- FIN to IDLE unconditionally.
REQ-013 On the accept edge (IDLE, start=1), the block SHALL latch:
- mcand = zero-extended |dataA| to 2*WIDTH bits.
- mplier = |dataB| as WIDTH bits.
- neg = signed_mode & (dataA[MSB] ^ dataB[MSB]).
- acc = 0 and iteration counter = 0.
REQ-014 The absolute value SHALL be taken only when signed_mode=1, and |-2^(WIDTH-1)| SHALL equal 2^(WIDTH-1) as an unsigned value.
REQ-015 Each RUN edge SHALL perform exactly one iteration:
- If mplier[0]=1, add mcand to acc (2*WIDTH bits, no overflow possible).
- Shift mplier right by 1 and mcand left by 1.
- Increment the counter.
REQ-016 On the FIN edge, the block SHALL set dataOut to neg ? -acc : acc (two's complement, 2*WIDTH bits) and set done to 1.
REQ-017 done SHALL be high for exactly one cycle, and dataOut SHALL hold its value until the next FIN edge or reset.
REQ-018 Latency SHALL be fixed: with the accept edge as E0, iterations occur on E1..E_WIDTH, and dataOut/done update on E_(WIDTH+1), independent of operand values.
REQ-019 busy SHALL rise after E0 and fall after E_(WIDTH+1).
REQ-020 A start pulse while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-021 A start pulse in the cycle where done=1 SHALL be accepted, allowing back-to-back operations every WIDTH+2 cycles.
REQ-022 Operand inputs SHALL be don't-care outside the accept edge.

Reset
REQ-023 While reset=1, the block SHALL immediately hold:
- state = IDLE.
- busy = 0, done = 0, dataOut = 0.
- acc, mcand, mplier, counter and neg = 0.
REQ-024 A reset asserted mid-operation SHALL abort it with no done pulse, and the first start after reset deasserts SHALL be accepted normally.
REQ-025 Outputs SHALL depend only on registered state, with no combinational path from inputs to outputs.

Structure
REQ-026 The FSM state typedef, state encodings (IDLE=0, RUN=1, FIN=2) and the default WIDTH constant SHALL live in shared package seq_mul_pkg.
REQ-027 The counter width SHALL be $clog2(WIDTH+1).
REQ-028 The block SHALL be a single module with no sub-module, containing one sequential process and one combinational next-state process.

Verification (WIDTH=32 unless stated)
REQ-029 Unsigned basic: dataA=3, dataB=5, signed_mode=0 -> dataOut=15, with done exactly 33 cycles after the accept edge.
REQ-030 Unsigned max: dataA=dataB=0xFFFFFFFF, signed_mode=0 -> dataOut=0xFFFFFFFE00000001; with signed_mode=1 -> dataOut=1.
REQ-031 Signed extremes: dataA=0x80000000, dataB=1, signed_mode=1 -> dataOut=0xFFFFFFFF80000000; dataA=dataB=0x80000000, signed_mode=1 -> dataOut=0x4000000000000000.
REQ-032 Handshake:
- Pulse start again 5 cycles after accept with different operands -> first result unchanged, only one done pulse.
- Start asserted during the done cycle -> second result 34 cycles after the first.
REQ-033 Reset mid-operation: assert reset at iteration 10 -> dataOut=0, busy=0, no done pulse; a subsequent 7*6 -> dataOut=42.
REQ-034 Parameter sweep: WIDTH=8, 1000 random operands in both modes, checked against a reference model; done latency SHALL equal 9 cycles.
